mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Load/store initiator that sits between the CPU memory stage and the `Ram` data memory. It turns byte-addressed LB/LBU/LH/LHU/LW/SB/SH/SW requests into `Ram` port cycles (`ena`, `addr`, `switch`, `we`, `data_in`) and extracts and extends load data from the `Ram` word output. Sub-word stores at a non-zero byte offset use a read-modify-write sequence. Misaligned, out-of-range and illegal requests are rejected without touching memory.

## Interface

Parameters:
- `ADDR_LIMIT`, default 4096: byte-address bound. Must be a multiple of 4 and at most 4096 (1024 `Ram` words).

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned` in 1: loads only; zero-extend instead of sign-extend.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: consumer accepts the response.
- `resp_rdata` out 32: extended load data; 0 for stores and exceptions.
- `resp_exc` out 2: 00 ok, 01 misaligned, 10 out of range, 11 illegal size.
- `ram_ena` out 1: drives `Ram` `ena`.
- `ram_we` out 1: drives `Ram` `we`.
- `ram_switch` out 3: 100 byte, 010 half, 001 word.
- `ram_addr` out 32: word index, `{22'b0, addr[11:2]}`.
- `ram_wdata` out 32: drives `Ram` `data_in`.
- `ram_rdata` in 32: from `Ram` `data_out`. It is combinational, valid in the same cycle as `ena`/`addr`.

## Operation

- FSM states: IDLE, ACCESS, MERGE, RESP. All state and output registers are cleared by `rst_n`.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid`, the request is latched (op, addr, wdata) at the clock edge.
  - Checks, in priority order: illegal size (11); misaligned (half with `addr[0]`=1, word with `addr[1:0]`≠0); `addr` ≥ `ADDR_LIMIT`.
  - If any check fails, go to RESP with the matching `resp_exc`. No `Ram` cycle is issued.
  - Otherwise go to ACCESS.
- ACCESS drives `ram_ena`=1 and `ram_addr` = word index. The action depends on the request type:
  - Load: `ram_switch`=001, `ram_we`=0. The full word is captured at the edge; go to RESP.
  - Direct store (SW, SH at `addr[1]`=0, SB at `addr[1:0]`=0):
    - `ram_we`=1, `ram_switch` = 001/010/100 by size, `ram_wdata` = `req_wdata`.
    - The `Ram` writes at the edge; go to RESP.
  - RMW store (SB at offset 1–3, SH at `addr[1]`=1): `ram_switch`=001, `ram_we`=0. The word is captured; go to MERGE.
- MERGE:
  - `ram_ena`=1, `ram_we`=1, `ram_switch`=001.
  - `ram_wdata` = captured word with the target lane replaced. Byte lanes are little-endian: lane k = bits [8k+7:8k]. Half lane h = bits [16h+15:16h].
  - Go to RESP.
- Load extraction:
  - Byte = `word >> 8*addr[1:0]`; half = `word >> 16*addr[1]`.
  - Extend to 32 bits: sign-extend unless `req_unsigned`.
  - LW ignores `req_unsigned`.
- RESP:
  - `resp_valid`=1; `resp_rdata` and `resp_exc` are registered and stable.
  - Hold until `resp_ready`=1, then go to IDLE.
  - `req_ready`=0 in every state other than IDLE, so there is no back-to-back accept during RESP.
- Idle values whenever the `Ram` is not driven: `ram_ena`=0, `ram_we`=0, `ram_switch`=000, `ram_addr`=0, `ram_wdata`=0.

## Timing

- Reset values:
  - State IDLE, so `req_ready`=1 (also during reset).
  - `resp_valid`=0, `resp_rdata`=0, `resp_exc`=00.
  - All `ram_*` outputs are 0.
- Latency, with the request accepted at edge 0:
  - Exception: `resp_valid` in cycle 1.
  - Load or direct store: ACCESS in cycle 1, `resp_valid` in cycle 2.
  - RMW store: ACCESS in cycle 1, MERGE in cycle 2, `resp_valid` in cycle 3.
- `ram_*` outputs are registered or decoded from state only. They never depend combinationally on `req_*`.
- Throughput:
  - With `resp_ready` held at 1: one load per 3 cycles, one RMW store per 4.
  - A response accepted in cycle n gives `req_ready`=1 in cycle n+1.
- Reset mid-operation:
  - `ram_we` and `ram_ena` drop asynchronously and the pending response is discarded.
  - Reset during MERGE before the edge means no write occurs and the memory word is unchanged.
- `req_*` inputs are ignored outside IDLE; the latched copy is used.

## Test plan

- Reset: assert `rst_n`=0 mid-run → all outputs 0, `req_ready`=1, `resp_valid`=0.
- SW then LW:
  - SW 0xDEADBEEF at addr 0x10 → cycle 1 shows `ram_addr`=4, `ram_switch`=001, `ram_we`=1; `resp_valid` in cycle 2 with `resp_exc`=00.
  - LW 0x10 → `resp_rdata`=0xDEADBEEF.
- Loads on word 0xDEADBEEF:
  - LB 0x13 → 0xFFFFFFDE.
  - LBU 0x13 → 0x000000DE.
  - LH 0x12 → 0xFFFFDEAD.
  - LHU 0x10 → 0x0000BEEF.
- Sub-word stores on word 0xDEADBEEF:
  - SB 0x55 at 0x11 → cycle 1 read (`ram_we`=0), cycle 2 `ram_wdata`=0xDEAD55EF with `ram_switch`=001, `resp_valid` in cycle 3.
  - SB 0x77 at 0x10 → single `ram_switch`=100 write; word becomes 0xDEAD5577.
- Exceptions:
  - LW 0x12 → `resp_exc`=01.
  - LB 0x1000 → `resp_exc`=10.
  - `req_size`=11 → `resp_exc`=11.
  - All three: `ram_ena` never asserted, response in cycle 1.
- Backpressure and reset:
  - `resp_ready`=0 for 3 cycles → `resp_*` stable and `req_ready`=0 throughout.
  - Reset asserted during MERGE → `ram_we` falls immediately and a later LW returns the unmodified word.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: load/store initiator between the CPU memory stage and the
// word-organised Ram. It turns byte-addressed LB/LBU/LH/LHU/LW/SB/SH/SW
// requests into Ram port cycles, and extracts and extends load data.
// Sub-word stores at a non-zero byte offset use a read-modify-write sequence.
// Illegal, misaligned and out-of-range requests never touch the Ram.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   req_valid/req_ready          request handshake (ready only in IDLE)
//   req_we, req_size,
//   req_unsigned, req_addr,
//   req_wdata                    request payload, latched on accept
//   resp_valid/resp_ready        response handshake
//   resp_rdata, resp_exc         extended load data, exception code
//   ram_ena, ram_we, ram_switch,
//   ram_addr, ram_wdata          registered Ram controls
//   ram_rdata                    combinational Ram read data
module mem_access_ctrl #(
  parameter int unsigned ADDR_LIMIT = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_exc,
  output logic        ram_ena,
  output logic        ram_we,
  output logic [2:0]  ram_switch,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  localparam int unsigned WORD_W = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  localparam logic [1:0] EXC_OK       = 2'b00;
  localparam logic [1:0] EXC_MISALIGN = 2'b01;
  localparam logic [1:0] EXC_RANGE    = 2'b10;
  localparam logic [1:0] EXC_ILLEGAL  = 2'b11;

  localparam logic [2:0] SW_BYTE = 3'b100;
  localparam logic [2:0] SW_HALF = 3'b010;
  localparam logic [2:0] SW_WORD = 3'b001;
  localparam logic [2:0] SW_NONE = 3'b000;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ACCESS = 2'b01,
    S_MERGE  = 2'b10,
    S_RESP   = 2'b11
  } state_t;

  state_t      state;

  // Latched copy of the accepted request
  logic        op_we;
  logic [1:0]  op_size;
  logic        op_uns;
  logic [1:0]  op_off;
  logic        op_rmw;
  logic [15:0] op_wdata;

  logic [1:0]        req_exc_c;
  logic              req_rmw_c;
  logic [2:0]        req_switch_c;
  logic [7:0]        ld_byte_c;
  logic [15:0]       ld_half_c;
  logic [WORD_W-1:0] ld_data_c;
  logic [WORD_W-1:0] merge_c;

  // Request checks in priority order: illegal size, misaligned, out of range
  always_comb begin
    req_exc_c = EXC_OK;
    if (req_size == SZ_ILL) begin
      req_exc_c = EXC_ILLEGAL;
    end else if ((req_size == SZ_HALF && req_addr[0]) ||
                 (req_size == SZ_WORD && req_addr[1:0] != 2'b00)) begin
      req_exc_c = EXC_MISALIGN;
    end else if (req_addr >= 32'(ADDR_LIMIT)) begin
      req_exc_c = EXC_RANGE;
    end
  end

  // Sub-word stores off lane 0 cannot be written directly by the Ram
  assign req_rmw_c = req_we &&
                     ((req_size == SZ_BYTE && req_addr[1:0] != 2'b00) ||
                      (req_size == SZ_HALF && req_addr[1]));

  // Ram lane select for a direct store
  always_comb begin
    case (req_size)
      SZ_BYTE: req_switch_c = SW_BYTE;
      SZ_HALF: req_switch_c = SW_HALF;
      default: req_switch_c = SW_WORD;
    endcase
  end

  // Load extraction and extension from the live Ram word
  always_comb begin
    ld_byte_c = 8'(ram_rdata >> {op_off, 3'b000});
    ld_half_c = 16'(ram_rdata >> {op_off[1], 4'b0000});
    case (op_size)
      SZ_BYTE: ld_data_c = op_uns ? {24'b0, ld_byte_c}
                                  : {{24{ld_byte_c[7]}}, ld_byte_c};
      SZ_HALF: ld_data_c = op_uns ? {16'b0, ld_half_c}
                                  : {{16{ld_half_c[15]}}, ld_half_c};
      default: ld_data_c = ram_rdata;
    endcase
  end

  // Read word with the target lane replaced; only offset-2 halves get here
  always_comb begin
    merge_c = ram_rdata;
    if (op_size == SZ_BYTE) begin
      case (op_off)
        2'd0:    merge_c[7:0]   = op_wdata[7:0];
        2'd1:    merge_c[15:8]  = op_wdata[7:0];
        2'd2:    merge_c[23:16] = op_wdata[7:0];
        default: merge_c[31:24] = op_wdata[7:0];
      endcase
    end else begin
      merge_c[31:16] = op_wdata;
    end
  end

  // Control FSM with all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_exc   <= EXC_OK;
      ram_ena    <= 1'b0;
      ram_we     <= 1'b0;
      ram_switch <= SW_NONE;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      op_we      <= 1'b0;
      op_size    <= SZ_BYTE;
      op_uns     <= 1'b0;
      op_off     <= 2'b00;
      op_rmw     <= 1'b0;
      op_wdata   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_we     <= req_we;
            op_size   <= req_size;
            op_uns    <= req_unsigned;
            op_off    <= req_addr[1:0];
            op_rmw    <= req_rmw_c;
            op_wdata  <= req_wdata[15:0];
            req_ready <= 1'b0;
            if (req_exc_c != EXC_OK) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_exc   <= req_exc_c;
              resp_rdata <= '0;
            end else begin
              state    <= S_ACCESS;
              ram_ena  <= 1'b1;
              ram_addr <= {22'b0, req_addr[11:2]};
              if (req_we && !req_rmw_c) begin
                ram_we     <= 1'b1;
                ram_switch <= req_switch_c;
                ram_wdata  <= req_wdata;
              end else begin
                ram_we     <= 1'b0;
                ram_switch <= SW_WORD;
                ram_wdata  <= '0;
              end
            end
          end
        end
        S_ACCESS: begin
          if (op_rmw) begin
            state      <= S_MERGE;
            ram_we     <= 1'b1;
            ram_switch <= SW_WORD;
            ram_wdata  <= merge_c;
          end else begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_exc   <= EXC_OK;
            resp_rdata <= op_we ? '0 : ld_data_c;
            ram_ena    <= 1'b0;
            ram_we     <= 1'b0;
            ram_switch <= SW_NONE;
            ram_addr   <= '0;
            ram_wdata  <= '0;
          end
        end
        S_MERGE: begin
          state      <= S_RESP;
          resp_valid <= 1'b1;
          resp_exc   <= EXC_OK;
          resp_rdata <= '0;
          ram_ena    <= 1'b0;
          ram_we     <= 1'b0;
          ram_switch <= SW_NONE;
          ram_addr   <= '0;
          ram_wdata  <= '0;
        end
        S_RESP: begin
          if (resp_ready) begin
            state      <= S_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_exc   <= EXC_OK;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomised bench for mem_access_ctrl. A byte-array reference memory and a
// cycle-count timing model predict every output each cycle; directed cases
// pin the model with hand-computed values.
module tb_mem_access_ctrl;

  localparam int unsigned LIMIT = 4096;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_exc;
  logic        ram_ena;
  logic        ram_we;
  logic [2:0]  ram_switch;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_exc(resp_exc), .ram_ena(ram_ena),
    .ram_we(ram_we), .ram_switch(ram_switch), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Ram environment: combinational read, lane-0 writes for byte/half
  logic [31:0] mem_w [0:1023];
  assign ram_rdata = mem_w[ram_addr[9:0]];
  always @(posedge clk) begin
    if (ram_ena && ram_we) begin
      case (ram_switch)
        3'b100:  mem_w[ram_addr[9:0]][7:0]  <= ram_wdata[7:0];
        3'b010:  mem_w[ram_addr[9:0]][15:0] <= ram_wdata[15:0];
        3'b001:  mem_w[ram_addr[9:0]]       <= ram_wdata;
        default: ;
      endcase
    end
  end

  int n_vec = 0;
  int n_err = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  logic [7:0]  ref_b [0:LIMIT-1];
  bit          busy = 0;
  int          k = 0;
  int          lat = 0;
  logic        m_we;
  logic [31:0] m_addr;
  logic [1:0]  m_exc;
  logic [31:0] m_rdata;
  logic [31:0] m_ram_wd;
  logic [31:0] m_old_word;
  logic [2:0]  m_sw_access;

  function automatic logic [31:0] word_at(int base);
    return {ref_b[base+3], ref_b[base+2], ref_b[base+1], ref_b[base]};
  endfunction

  function automatic void model_accept(logic we, logic [1:0] sz, logic uns,
                                       logic [31:0] a, logic [31:0] wd);
    int nb;
    int base;
    logic [31:0] v;
    bit rmw;
    m_we = we;
    m_addr = a;
    m_rdata = '0;
    m_ram_wd = '0;
    m_sw_access = 3'b001;
    if (sz == 2'b11) m_exc = 2'b11;
    else if ((sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)) m_exc = 2'b01;
    else if (a >= 32'(LIMIT)) m_exc = 2'b10;
    else m_exc = 2'b00;
    if (m_exc != 2'b00) begin
      lat = 1;
      return;
    end
    nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    base = int'(a) & ~3;
    m_old_word = word_at(base);
    if (!we) begin
      v = '0;
      for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_b[int'(a) + i];
      if (!uns && nb == 1 && v[7])  v[31:8]  = '1;
      if (!uns && nb == 2 && v[15]) v[31:16] = '1;
      m_rdata = v;
      lat = 2;
    end else begin
      for (int i = 0; i < nb; i++) ref_b[int'(a) + i] = wd[8*i +: 8];
      rmw = (a[1:0] != 2'b00);
      lat = rmw ? 3 : 2;
      m_ram_wd = rmw ? word_at(base) : wd;
      if (!rmw) m_sw_access = (nb == 1) ? 3'b100 : (nb == 2) ? 3'b010 : 3'b001;
    end
  endfunction

  // Advance the model across one rising edge using the inputs held before it
  function automatic void model_edge();
    if (!busy) begin
      if (req_valid) begin
        model_accept(req_we, req_size, req_unsigned, req_addr, req_wdata);
        busy = 1;
        k = 1;
      end
    end else if (k >= lat) begin
      if (resp_ready) busy = 0;
    end else begin
      k++;
    end
  endfunction

  // A store whose write edge has not yet happened leaves memory untouched
  function automatic void model_reset();
    if (busy && m_we && m_exc == 2'b00 && k < lat) begin
      for (int i = 0; i < 4; i++) ref_b[(int'(m_addr) & ~3) + i] = m_old_word[8*i +: 8];
    end
    busy = 0;
  endfunction

  // Per-cycle compare of every output against the model
  always @(negedge clk) begin
    bit en_e;
    bit we_e;
    bit rv_e;
    en_e = busy && (k < lat);
    we_e = en_e && m_we && (k == lat - 1);
    rv_e = busy && (k >= lat);
    chk("req_ready", 32'(req_ready), 32'(!busy));
    chk("resp_valid", 32'(resp_valid), 32'(rv_e));
    chk("ram_ena", 32'(ram_ena), 32'(en_e));
    chk("ram_we", 32'(ram_we), 32'(we_e));
    chk("ram_addr", ram_addr, en_e ? (m_addr >> 2) : 32'd0);
    chk("ram_switch", 32'(ram_switch),
        en_e ? ((k == 1) ? 32'(m_sw_access) : 32'd1) : 32'd0);
    chk("ram_wdata", ram_wdata, we_e ? m_ram_wd : 32'd0);
    if (rv_e) begin
      chk("resp_rdata", resp_rdata, m_rdata);
      chk("resp_exc", 32'(resp_exc), 32'(m_exc));
    end
  end

  // ---------------- stimulus ----------------
  int          last_lat;
  logic [31:0] last_rdata;
  logic [1:0]  last_exc;
  bit          saw_ena;
  logic        rec_ena [1:3];
  logic        rec_we  [1:3];
  logic [2:0]  rec_sw  [1:3];
  logic [31:0] rec_addr[1:3];
  logic [31:0] rec_wd  [1:3];

  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic do_txn(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, input int hold);
    int waited;
    int n;
    waited = 0;
    req_valid = 1'b1;
    req_we = we;
    req_size = sz;
    req_unsigned = uns;
    req_addr = a;
    req_wdata = wd;
    resp_ready = 1'($urandom_range(0, 1));
    cycle();
    req_valid = 1'b0;
    req_we = 1'($urandom_range(0, 1));
    req_size = 2'($urandom_range(0, 3));
    req_addr = $urandom;
    req_wdata = $urandom;
    last_lat = 0;
    last_rdata = '0;
    last_exc = '0;
    saw_ena = 0;
    n = 1;
    while (busy && n < 20) begin
      if (n <= 3) begin
        rec_ena[n] = ram_ena;
        rec_we[n] = ram_we;
        rec_sw[n] = ram_switch;
        rec_addr[n] = ram_addr;
        rec_wd[n] = ram_wdata;
      end
      if (ram_ena) saw_ena = 1;
      if (resp_valid && last_lat == 0) begin
        last_lat = n;
        last_rdata = resp_rdata;
        last_exc = resp_exc;
      end
      if (k >= lat) begin
        resp_ready = 1'(waited >= hold);
        waited++;
      end else begin
        resp_ready = 1'($urandom_range(0, 1));
      end
      cycle();
      n++;
    end
    resp_ready = 1'b0;
    if (busy) begin
      n_vec++;
      n_err++;
      $display("FAIL txn_timeout: response never completed for addr %h", a);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $fatal(1, "transaction timeout");
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem_w[i] = $urandom;
      for (int b = 0; b < 4; b++) ref_b[4*i + b] = mem_w[i][8*b +: 8];
    end

    // Reset values
    cycle();
    cycle();
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_ram_ena", 32'(ram_ena), 32'd0);
    rst_n = 1'b1;
    cycle();

    // SW then loads on 0xDEADBEEF
    do_txn(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 0);
    chk("sw_c1_addr", rec_addr[1], 32'd4);
    chk("sw_c1_switch", 32'(rec_sw[1]), 32'd1);
    chk("sw_c1_we", 32'(rec_we[1]), 32'd1);
    chk("sw_lat", 32'(last_lat), 32'd2);
    chk("sw_exc", 32'(last_exc), 32'd0);
    do_txn(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0);
    chk("lw_0x10", last_rdata, 32'hDEADBEEF);
    do_txn(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1);
    chk("lb_0x13", last_rdata, 32'hFFFFFFDE);
    do_txn(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 0);
    chk("lbu_0x13", last_rdata, 32'h000000DE);
    do_txn(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 0);
    chk("lh_0x12", last_rdata, 32'hFFFFDEAD);
    do_txn(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 0);
    chk("lhu_0x10", last_rdata, 32'h0000BEEF);

    // Sub-word stores
    do_txn(1'b1, 2'b00, 1'b0, 32'h11, 32'h55, 0);
    chk("sb11_c1_we", 32'(rec_we[1]), 32'd0);
    chk("sb11_c2_wdata", rec_wd[2], 32'hDEAD55EF);
    chk("sb11_c2_switch", 32'(rec_sw[2]), 32'd1);
    chk("sb11_lat", 32'(last_lat), 32'd3);
    do_txn(1'b1, 2'b00, 1'b0, 32'h10, 32'h77, 0);
    chk("sb10_c1_switch", 32'(rec_sw[1]), 32'd4);
    chk("sb10_lat", 32'(last_lat), 32'd2);
    do_txn(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0);
    chk("lw_after_sb", last_rdata, 32'hDEAD5577);

    // Exceptions
    do_txn(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 0);
    chk("lw_mis_exc", 32'(last_exc), 32'd1);
    chk("lw_mis_lat", 32'(last_lat), 32'd1);
    chk("lw_mis_ena", 32'(saw_ena), 32'd0);
    do_txn(1'b0, 2'b00, 1'b0, 32'h1000, 32'h0, 0);
    chk("lb_range_exc", 32'(last_exc), 32'd2);
    chk("lb_range_ena", 32'(saw_ena), 32'd0);
    do_txn(1'b1, 2'b11, 1'b0, 32'h10, 32'h0, 2);
    chk("ill_exc", 32'(last_exc), 32'd3);
    chk("ill_lat", 32'(last_lat), 32'd1);
    chk("ill_ena", 32'(saw_ena), 32'd0);

    // Backpressure on a load
    do_txn(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 3);
    chk("bp_rdata", last_rdata, 32'hDEAD5577);

    // Reset during MERGE leaves the word unchanged
    do_txn(1'b1, 2'b10, 1'b0, 32'h14, 32'h11223344, 0);
    req_valid = 1'b1;
    req_we = 1'b1;
    req_size = 2'b00;
    req_addr = 32'h15;
    req_wdata = 32'hAA;
    cycle();
    req_valid = 1'b0;
    cycle();
    chk("merge_we_pre", 32'(ram_we), 32'd1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_ena", 32'(ram_ena), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_rvalid", 32'(resp_valid), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();
    do_txn(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 0);
    chk("lw_after_rst", last_rdata, 32'h11223344);

    // Randomised traffic
    for (int t = 0; t < 300; t++) begin
      logic [31:0] a;
      logic [1:0]  sz;
      sz = ($urandom_range(0, 19) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      case ($urandom_range(0, 9))
        0:       a = 32'(LIMIT - 4 + $urandom_range(0, 7));
        1:       a = $urandom;
        default: a = 32'($urandom_range(0, 63));
      endcase
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
      end
      do_txn(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
             ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3));
      if ($urandom_range(0, 3) == 0) cycle();
    end

    cycle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
